// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - MEM write-port bundle between the boot loader and the instruction memory
//   mem_wr_en    single-cycle write strobe
//   mem_wr_addr  word index to write
//   mem_wr_data  32-bit word to write
//   master: boot loader drives the port; slave: memory receives it
interface uart_boot_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [31:0]           mem_wr_data;

    modport master (
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data
    );

    modport slave (
        input mem_wr_en,
        input mem_wr_addr,
        input mem_wr_data
    );
endinterface

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART 8N1 receiver that loads a length-prefixed program image into MEM and releases the CPU
//   clk, resetn  system clock, synchronous active-low reset
//   rxd          asynchronous UART receive line (idle high)
//   mem          MEM write port (master side)
//   cpu_resetn   active-low processor reset, released only after a valid load
//   busy         load in progress; done / error: sticky completion status
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               rxd,
    uart_boot_loader_if.master mem,
    output logic               cpu_resetn,
    output logic               busy,
    output logic               done,
    output logic               error
);
    localparam int TW    = $clog2(CLKS_PER_BIT + 1);
    localparam int IW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] L_LEN0  = 3'd0;
    localparam logic [2:0] L_LEN1  = 3'd1;
    localparam logic [2:0] L_DATA  = 3'd2;
    localparam logic [2:0] L_LAST  = 3'd3;
    localparam logic [2:0] L_DONE  = 3'd4;
    localparam logic [2:0] L_ERROR = 3'd5;

    logic            rxd_meta_q, rxd_sync_q;
    logic [1:0]      rx_state_q, rx_state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid, frame_err;

    logic [2:0]            l_state_q, l_state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [IW-1:0]         len_q, len_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           word_q, word_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic [15:0]           len_word;

    // Receiver: sample at mid-bit; byte_valid / frame_err are combinational
    // pulses in the stop-sample cycle so the loader can react at that edge.
    always_comb begin
        rx_state_d = rx_state_q;
        timer_d    = timer_q + TW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                timer_d = '0;
                if (!rxd_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (timer_q == TW'(CLKS_PER_BIT / 2 - 1)) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
                    timer_d   = '0;
                    shift_d   = {rxd_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
                    timer_d    = '0;
                    rx_state_d = RX_IDLE;
                    byte_valid = rxd_sync_q;
                    frame_err  = !rxd_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign len_word = {shift_q, len_lo_q};

    always_comb begin
        l_state_d = l_state_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        word_d    = word_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (l_state_q)
            L_LEN0: begin
                if (frame_err) l_state_d = L_ERROR;
                else if (byte_valid) begin
                    len_lo_d  = shift_q;
                    l_state_d = L_LEN1;
                end
            end
            L_LEN1: begin
                if (frame_err) l_state_d = L_ERROR;
                else if (byte_valid) begin
                    if (len_word == 16'd0) l_state_d = L_DONE;
                    else if (32'(len_word) > 32'(DEPTH)) l_state_d = L_ERROR;
                    else begin
                        len_d     = len_word[IW-1:0];
                        idx_d     = '0;
                        lane_d    = 2'd0;
                        l_state_d = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (frame_err) l_state_d = L_ERROR;
                else if (byte_valid) begin
                    word_d[8*lane_q +: 8] = shift_q;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q[ADDR_WIDTH-1:0];
                        wr_data_d = {shift_q, word_q[23:0]};
                        idx_d     = idx_q + IW'(1);
                        // L_LAST covers the write cycle so done rises one cycle later.
                        if (idx_q + IW'(1) == len_q) l_state_d = L_LAST;
                    end
                end
            end
            L_LAST:  l_state_d = L_DONE;
            L_DONE:  l_state_d = L_DONE;
            L_ERROR: l_state_d = L_ERROR;
            default: l_state_d = L_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            l_state_q  <= L_LEN0;
            len_lo_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rx_state_q <= rx_state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            l_state_q  <= l_state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign mem.mem_wr_en   = wr_en_q;
    assign mem.mem_wr_addr = wr_addr_q;
    assign mem.mem_wr_data = wr_data_q;

    assign busy       = (l_state_q == L_LEN1) || (l_state_q == L_DATA) || (l_state_q == L_LAST);
    assign done       = (l_state_q == L_DONE);
    assign error      = (l_state_q == L_ERROR);
    assign cpu_resetn = done;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - scoreboard bench for uart_boot_loader
module tb_uart_boot_loader;
    localparam int CPB = 16;
    localparam int AW  = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic rxd = 1'b1;
    logic cpu_resetn, busy, done, error;

    uart_boot_loader_if #(.ADDR_WIDTH(AW)) mem_if ();

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rxd        (rxd),
        .mem        (mem_if),
        .cpu_resetn (cpu_resetn),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    logic [39:0] exp_q[$];
    int cyc = 0;
    int last_wr_cyc = 0;
    bit wr_seen = 0;
    int n_wr = 0;
    logic done_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe pops one expected (addr,data) pair.
    always @(negedge clk) begin
        logic [39:0] e;
        cyc++;
        if (resetn && mem_if.mem_wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(mem_if.mem_wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_if.mem_wr_addr), 64'(e[39:32]));
                check("wr_data", 64'(mem_if.mem_wr_data), 64'(e[31:0]));
            end
            last_wr_cyc = cyc;
            wr_seen = 1'b1;
            n_wr++;
        end
        if (resetn && done && !done_prev && wr_seen)
            check("done_after_wr", 64'(cyc - last_wr_cyc), 64'd1);
        done_prev = resetn ? done : 1'b0;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(posedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp);
        @(negedge clk);
        check(tag, 64'({cpu_resetn, busy, done, error}), 64'(exp));
    endtask

    task automatic check_all_reset(input string tag);
        check(tag, 64'({mem_if.mem_wr_en, mem_if.mem_wr_addr, mem_if.mem_wr_data,
                        cpu_resetn, busy, done, error}), 64'd0);
    endtask

    task automatic do_reset();
        rxd = 1'b1;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_reset("rst_hold");
        @(posedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_all_reset("rst_first_cycle");
        exp_q.delete();
        wr_seen = 1'b0;
        n_wr = 0;
    endtask

    task automatic end_test(input string tag, input int wr_exp, input logic [3:0] flags_exp);
        repeat (4) @(posedge clk);
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_wr_count"}, 64'(n_wr), 64'(wr_exp));
        check_flags({tag, "_flags"}, flags_exp);
    endtask

    // flags order: {cpu_resetn, busy, done, error}
    initial begin
        do_reset();

        // Two-word image
        send_ok(8'h02);
        check_flags("t1_busy_after_len0", 4'b0100);
        send_ok(8'h00);
        expect_wr(8'd0, 32'h0000_0013);
        send_ok(8'h13); send_ok(8'h00); send_ok(8'h00); send_ok(8'h00);
        check_flags("t1_busy_mid", 4'b0100);
        expect_wr(8'd1, 32'hFFDF_F06F);
        send_ok(8'h6F); send_ok(8'hF0); send_ok(8'hDF); send_ok(8'hFF);
        end_test("t1", 2, 4'b1010);

        // Empty image, later bytes ignored
        do_reset();
        send_ok(8'h00); send_ok(8'h00);
        end_test("t2", 0, 4'b1010);
        send_ok(8'hAA);
        end_test("t2_after_aa", 0, 4'b1010);
        check("t2_addr_hold", 64'({mem_if.mem_wr_addr, mem_if.mem_wr_data}), 64'd0);

        // N=257 too large; following bytes ignored
        do_reset();
        send_ok(8'h01); send_ok(8'h01);
        end_test("t3", 0, 4'b0001);
        send_ok(8'h00); send_ok(8'h01);
        end_test("t3_after", 0, 4'b0001);

        // Framing error on the 3rd data byte: no partial write
        do_reset();
        send_ok(8'h01); send_ok(8'h00); send_ok(8'hEF); send_ok(8'hBE);
        send_byte(8'hAD, 1'b0);
        end_test("t4", 0, 4'b0001);

        // Short glitch while idle, then a valid one-word load
        do_reset();
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        end_test("t5_glitch", 0, 4'b0000);
        send_ok(8'h01); send_ok(8'h00);
        expect_wr(8'd0, 32'h1234_5678);
        send_ok(8'h78); send_ok(8'h56); send_ok(8'h34); send_ok(8'h12);
        end_test("t5", 1, 4'b1010);

        // Reset in the middle of a frame discards the partial load
        do_reset();
        send_ok(8'h03); send_ok(8'h00); send_ok(8'h11); send_ok(8'h22); send_ok(8'h33);
        check_flags("t6_busy_before_rst", 4'b0100);
        rxd = 1'b0;
        repeat (CPB + CPB / 2) @(posedge clk);
        rxd = 1'b1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_reset("t6_in_reset");
        @(posedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_all_reset("t6_after_reset");
        exp_q.delete();
        wr_seen = 1'b0;
        n_wr = 0;
        repeat (2 * CPB) @(posedge clk);
        send_ok(8'h01); send_ok(8'h00);
        expect_wr(8'd0, 32'h0403_0201);
        send_ok(8'h01); send_ok(8'h02); send_ok(8'h03); send_ok(8'h04);
        end_test("t6", 1, 4'b1010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Writer side of the CPU's instruction memory. Receives a program image over the UART RXD line and writes it word by word into the SOC's word-addressed MEM array.
- Holds the CPU in reset until the image is complete. Releases it only after a valid load.
- Sits in SOC between the RXD pin, the MEM write port and the processor's reset input.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit (CLK_FREQ/BAUD, computed by the instantiating SOC); minimum 4.
- ADDR_WIDTH, 8: MEM word-address width; DEPTH = 2**ADDR_WIDTH words (256).

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous, active-low reset.
- rxd  input  1  asynchronous UART receive line, idle high.
- mem_wr_en  output  1  single-cycle MEM write strobe.
- mem_wr_addr  output  ADDR_WIDTH  MEM word index to write.
- mem_wr_data  output  32  word to write.
- cpu_resetn  output  1  active-low reset to the processor.
- busy  output  1  a load is in progress (first length byte received, not yet done or error).
- done  output  1  image loaded successfully (sticky).
- error  output  1  load aborted (sticky).

Behaviour:
- Reset is synchronous, active-low, on clk. While resetn=0 and in the first cycle after it rises:
  - mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, cpu_resetn=0, busy=0, done=0, error=0.
  - Both FSMs in their idle/first state.
  - Any partial byte or word is discarded.
- rxd passes through a 2-flop synchroniser (reset value 1). All receiver decisions use the synchronised value.
- Receiver FSM:
  - RX_IDLE: wait for synchronised rxd=0. Then go to RX_START and clear the bit-timer.
  - RX_START: after CLKS_PER_BIT/2 cycles, sample the line.
    - 0: go to RX_DATA, timer cleared.
    - 1: glitch; return to RX_IDLE, no byte.
  - RX_DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, shifted into the byte register. Then go to RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT cycles.
    - 1: byte_valid pulses for exactly 1 cycle with the byte.
    - 0: frame_err pulses for 1 cycle.
    - Either way return to RX_IDLE.
- Loader FSM, advancing only on byte_valid/frame_err pulses:
  - L_LEN0: byte is word count N[7:0]. Set busy=1, go to L_LEN1.
  - L_LEN1: byte is N[15:8].
    - N=0: go to L_DONE.
    - N>DEPTH: go to L_ERROR.
    - Otherwise: go to L_DATA with word index=0, lane=0.
  - L_DATA:
    - Bytes are assembled little-endian: lane 0 goes to bits [7:0], up to lane 3 at bits [31:24].
    - On lane 3, in the next cycle: mem_wr_en=1 for one cycle, mem_wr_addr=word index, mem_wr_data=assembled word.
    - The index then increments; lane wraps to 0.
    - After word N-1 is written, go to L_DONE.
  - L_DONE: done=1, busy=0, cpu_resetn=1, starting the cycle after the last write (or the cycle after the L_LEN1 byte when N=0). Further bytes are ignored: no writes, no state change.
  - L_ERROR: error=1, busy=0, cpu_resetn stays 0. All further bytes are ignored until resetn.
- A frame_err in any loader state except L_DONE goes to L_ERROR. No write occurs for a partial word.
- mem_wr_addr and mem_wr_data hold their last values when mem_wr_en=0.
- Word index arithmetic is ADDR_WIDTH+1 bits, so N=DEPTH is legal and the final address is DEPTH-1 with no wrap.
- done and error are mutually exclusive. Both are cleared only by resetn.
- Latency: mem_wr_en occurs 1 cycle after the stop-bit sample of the 4th byte of a word.

Test Plan (CLKS_PER_BIT=16, ADDR_WIDTH=8, serial frames 8N1):
- Send 02 00 13 00 00 00 6F F0 DF FF -> writes (addr 0, 0x00000013) then (addr 1, 0xFFDFF06F), one mem_wr_en pulse each. done=1 and cpu_resetn=1 one cycle after the 2nd write. error=0.
- Send 00 00 -> no mem_wr_en. done=1 and cpu_resetn=1 one cycle after the 2nd byte's stop sample. Then send AA -> no write, outputs unchanged.
- Send 01 01 (N=257) -> error=1, busy=0, cpu_resetn=0, no writes. Then send 00 01 (N=256) -> still no change.
- Send 01 00 EF BE, then a frame with stop bit 0 -> error=1, no mem_wr_en, done stays 0.
- Pulse rxd low for 4 cycles while idle -> no byte accepted; loader stays in L_LEN0 and busy=0. A following valid 01 00 78 56 34 12 -> write (0, 0x12345678), done=1.
- Start load 03 00 11 22 33, then resetn=0 for 2 cycles mid-frame -> all outputs return to reset values. A fresh 01 00 01 02 03 04 -> single write (0, 0x04030201), done=1.
